psk_frame_packer: RTL and testbench

//  Upstream stage of the TX Sync_FIFO. Wraps raw payload bytes into PSK air frames:

---
 rtl/psk_frame_packer.sv | 164 ++++++++++++++++
 tb/tb_psk_frame_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_frame_packer.sv
// PSK air-frame packer: preamble, sync word, payload bytes and a CRC-8 trailer,
// emitted as an AXI-Stream byte stream qualified by the shared clock enable.
module psk_frame_packer #(
  parameter int unsigned PREAMBLE_LEN  = 8,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [15:0] SYNC_WORD     = 16'hD391,
  parameter int unsigned MAX_PAYLOAD   = 255,
  parameter logic [7:0]  CRC_POLY      = 8'h07
) (
  input  logic       s_axis_aclk,
  input  logic       s_axis_aresetn,
  input  logic       s_axis_aclken,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int PAY_W = $clog2(MAX_PAYLOAD + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(MAX_PAYLOAD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_PAY,
    ST_CRC
  } state_t;

  state_t           state_q,    state_d;
  logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [PAY_W-1:0] pay_cnt_q,  pay_cnt_d;
  logic             sync_sel_q, sync_sel_d;
  logic [7:0]       crc_q,      crc_d;
  logic [7:0]       tdata_q,    tdata_d;
  logic             tvalid_q,   tvalid_d;
  logic             tlast_q,    tlast_d;
  logic             tuser_q,    tuser_d;
  logic             ld;
  logic             accept;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] v;
    v = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      v = v[7] ? ((v << 1) ^ CRC_POLY) : (v << 1);
    end
    return v;
  endfunction

  // The output register may only be reloaded when empty or being drained.
  assign ld            = s_axis_aclken & (~tvalid_q | m_axis_tready);
  assign s_axis_tready = (state_q == ST_PAY) & (~tvalid_q | m_axis_tready);
  assign accept        = ld & s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    sync_sel_d = sync_sel_q;
    crc_d      = crc_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    if (ld) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Frame start is triggered by tvalid alone; the byte itself waits for PAY.
          if (s_axis_tvalid) begin
            tdata_d    = PREAMBLE_BYTE;
            tvalid_d   = 1'b1;
            tuser_d    = 1'b1;
            pre_cnt_d  = PRE_W'(1);
            pay_cnt_d  = '0;
            crc_d      = 8'h00;
            sync_sel_d = 1'b0;
            state_d    = (PREAMBLE_LEN == 1) ? ST_SYNC : ST_PRE;
          end
        end
        ST_PRE: begin
          tdata_d   = PREAMBLE_BYTE;
          tvalid_d  = 1'b1;
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
          if (pre_cnt_q == PRE_LAST) begin
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          tvalid_d = 1'b1;
          if (!sync_sel_q) begin
            tdata_d    = SYNC_WORD[15:8];
            sync_sel_d = 1'b1;
          end else begin
            tdata_d    = SYNC_WORD[7:0];
            sync_sel_d = 1'b0;
            pay_cnt_d  = '0;
            crc_d      = 8'h00;
            state_d    = ST_PAY;
          end
        end
        ST_PAY: begin
          // No input byte this enable leaves a bubble; the frame simply waits.
          if (accept) begin
            tdata_d   = s_axis_tdata;
            tvalid_d  = 1'b1;
            crc_d     = crc8_update(crc_q, s_axis_tdata);
            pay_cnt_d = pay_cnt_q + PAY_W'(1);
            if (s_axis_tlast || (pay_cnt_q == PAY_LAST)) begin
              state_d = ST_CRC;
            end
          end
        end
        ST_CRC: begin
          tdata_d  = crc_q;
          tvalid_d = 1'b1;
          tlast_d  = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      pay_cnt_q  <= '0;
      sync_sel_q <= 1'b0;
      crc_q      <= 8'h00;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      sync_sel_q <= sync_sel_d;
      crc_q      <= crc_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_psk_frame_packer.sv
// Randomized bench for psk_frame_packer: a frame-level reference model predicts
// the output byte stream; a negedge monitor compares every transfer.
module tb_psk_frame_packer;

  localparam int PRE_LEN = 4;
  localparam int MAX_PAY = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       aclken = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b0;
  logic       m_tlast;
  logic       m_tuser;

  int n_vec = 0;
  int n_err = 0;
  int n_frames = 0;

  logic [9:0]  exp_q[$];  // {tuser, tlast, data}
  logic [8:0]  src_q[$];  // {tlast, data}
  int          mdl_n = 0;
  logic [7:0]  mdl_crc = 8'h00;
  logic        s_hs = 1'b0;
  logic        hold_prev = 1'b0;
  logic [10:0] held_val = '0;

  psk_frame_packer #(
    .PREAMBLE_LEN (PRE_LEN),
    .PREAMBLE_BYTE(8'h55),
    .SYNC_WORD    (16'hD391),
    .MAX_PAYLOAD  (MAX_PAY),
    .CRC_POLY     (8'h07)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_aresetn(rst_n),
    .s_axis_aclken (aclken),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial CRC-8: shift the data in MSB first, feedback = crc[7] ^ data bit.
  function automatic logic [7:0] crc_ref(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  task automatic model_push(input logic [8:0] pkt[$]);
    foreach (pkt[i]) begin
      if (mdl_n == 0) begin
        for (int k = 0; k < PRE_LEN; k++) exp_q.push_back({(k == 0), 1'b0, 8'h55});
        exp_q.push_back({2'b00, 8'hD3});
        exp_q.push_back({2'b00, 8'h91});
        mdl_crc = 8'h00;
      end
      exp_q.push_back({2'b00, pkt[i][7:0]});
      mdl_crc = crc_ref(mdl_crc, pkt[i][7:0]);
      mdl_n++;
      if (pkt[i][8] || mdl_n == MAX_PAY) begin
        exp_q.push_back({2'b01, mdl_crc});
        mdl_n = 0;
      end
    end
  endtask

  task automatic gen_pkts(input int n, output logic [8:0] pkt[$]);
    pkt.delete();
    for (int p = 0; p < n; p++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) pkt.push_back({(b == len - 1), 8'($urandom)});
    end
  endtask

  // Monitor: a transfer seen here happens on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) check_eq("hold_stable", {m_tvalid, m_tuser, m_tlast, m_tdata}, held_val);
      if (m_tvalid && !m_tready) check_eq("s_tready_blocked", s_tready, 1'b0);
      if (aclken && m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", {m_tuser, m_tlast, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check_eq("frame_byte", {m_tuser, m_tlast, m_tdata}, e);
          if (e[8]) begin
            n_frames++;
            $display("frame %0d: crc %02h", n_frames, m_tdata);
          end
        end
      end
      s_hs      = aclken && s_tvalid && s_tready;
      hold_prev = m_tvalid && !m_tready;
      held_val  = {m_tvalid, m_tuser, m_tlast, m_tdata};
    end else begin
      s_hs      = 1'b0;
      hold_prev = 1'b0;
    end
  end

  task automatic drive_step(input int en_pct, input int rdy_pct);
    if (s_hs) begin
      src_q.delete(0);
      s_tvalid = 1'b0;
    end
    if (!s_tvalid && src_q.size() > 0 && $urandom_range(99) < 75) begin
      s_tvalid = 1'b1;
      {s_tlast, s_tdata} = src_q[0];
    end
    aclken   = ($urandom_range(99) < en_pct);
    m_tready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic freeze_check();
    logic [10:0] snap;
    aclken = 1'b0;
    if (src_q.size() > 0) begin
      s_tvalid = 1'b1;
      {s_tlast, s_tdata} = src_q[0];
    end
    snap = {m_tvalid, m_tuser, m_tlast, m_tdata};
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      check_eq("freeze_out", {m_tvalid, m_tuser, m_tlast, m_tdata}, snap);
    end
    $display("freeze: 100 clocks with clock enable low");
  endtask

  task automatic run_phase(input logic [8:0] pkt[$], input int freeze_at,
                           input int en_pct, input int rdy_pct);
    model_push(pkt);
    foreach (pkt[i]) src_q.push_back(pkt[i]);
    for (int cyc = 0; cyc < 30000 && (src_q.size() > 0 || exp_q.size() > 0); cyc++) begin
      @(posedge clk); #1;
      drive_step(en_pct, rdy_pct);
      if (cyc == freeze_at) freeze_check();
    end
    check_eq("drain", src_q.size() + exp_q.size(), 0);
    src_q.delete();
    exp_q.delete();
    s_tvalid = 1'b0;
  endtask

  task automatic reset_in_pay();
    logic [8:0] pkt[$];
    logic       hit;
    hit = 1'b0;
    pkt = '{9'h0AA, 9'h0BB, 9'h1CC};
    model_push(pkt);
    foreach (pkt[i]) src_q.push_back(pkt[i]);
    for (int cyc = 0; cyc < 5000 && !hit; cyc++) begin
      @(posedge clk); #1;
      drive_step(60, 70);
      #1 hit = s_tready;
    end
    check_eq("reach_pay", hit, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst_m_tdata", m_tdata, 8'h00);
    check_eq("rst_m_tuser", m_tuser, 1'b0);
    check_eq("rst_m_tlast", m_tlast, 1'b0);
    check_eq("rst_s_tready", s_tready, 1'b0);
    $display("reset asserted mid-payload");
    exp_q.delete();
    src_q.delete();
    mdl_n    = 0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] pkt[$];
    // Reset state, including enable and input activity while held in reset.
    #12;
    aclken   = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("init_m_tvalid", m_tvalid, 1'b0);
    check_eq("init_m_tdata", m_tdata, 8'h00);
    check_eq("init_m_tuser", m_tuser, 1'b0);
    check_eq("init_m_tlast", m_tlast, 1'b0);
    check_eq("init_s_tready", s_tready, 1'b0);
    s_tvalid = 1'b0;
    aclken   = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    pkt = '{9'h001, 9'h102};
    run_phase(pkt, -1, 100, 100);
    pkt = '{9'h101};
    run_phase(pkt, -1, 50, 100);
    pkt = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h105};
    run_phase(pkt, -1, 60, 70);
    gen_pkts(20, pkt);
    run_phase(pkt, 150, 40, 65);
    reset_in_pay();
    gen_pkts(20, pkt);
    run_phase(pkt, -1, 50, 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
